// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer for the execute stage.
// Fixed-latency multiply, radix-2 restoring divide, result held until accepted.
// Optional feature: define MDU_ZERO_BYPASS_EN to short-cut any op whose rs1 is zero.
module mdu_sequencer #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int unsigned CntMax = (XLEN > MUL_LATENCY) ? XLEN : MUL_LATENCY;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [XLEN-1:0] MostNeg = {1'b1, {(XLEN-1){1'b0}}};

`ifdef MDU_ZERO_BYPASS_EN
  localparam bit ZeroBypass = 1'b1;
`else
  localparam bit ZeroBypass = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, rem_q, rem_d, result_q, result_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d;

  // Incoming op decode; only DIV/REM (op bit0 clear) are signed divides
  logic            in_div, in_sdiv, in_neg1, in_neg2;
  logic [XLEN-1:0] mag1, mag2;
  assign in_div  = op_i[2];
  assign in_sdiv = op_i[2] & ~op_i[0];
  assign in_neg1 = in_sdiv & rs1_i[XLEN-1];
  assign in_neg2 = in_sdiv & rs2_i[XLEN-1];
  assign mag1    = in_neg1 ? -rs1_i : rs1_i;
  assign mag2    = in_neg2 ? -rs2_i : rs2_i;

  // Multiply on sign/zero-extended operands; the 2*XLEN+2 product is exact modulo its width
  logic                mul_sa, mul_sb;
  logic [2*XLEN+1:0]   mul_a, mul_b, product;
  logic [XLEN-1:0]     mul_res;
  assign mul_sa  = ((op_q == 3'd1) || (op_q == 3'd2)) & a_q[XLEN-1];
  assign mul_sb  = (op_q == 3'd1) & b_q[XLEN-1];
  assign mul_a   = {{(XLEN+2){mul_sa}}, a_q};
  assign mul_b   = {{(XLEN+2){mul_sb}}, b_q};
  assign product = mul_a * mul_b;
  assign mul_res = (op_q == 3'd0) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

  // One restoring step: a_q shifts the dividend out and the quotient in
  logic [XLEN:0]   rem_sh, diff;
  logic [XLEN-1:0] div_res;
  assign rem_sh  = {rem_q, a_q[XLEN-1]};
  assign diff    = rem_sh - {1'b0, b_q};
  assign div_res = op_q[1] ? (r_neg_q ? -rem_q : rem_q) : (q_neg_q ? -a_q : a_q);

  // Next-state, datapath updates and flush override
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (valid_i && !flush_i) begin
          op_d    = op_i;
          cnt_d   = '0;
          a_d     = rs1_i;
          b_d     = rs2_i;
          rem_d   = '0;
          q_neg_d = 1'b0;
          r_neg_d = 1'b0;
          if (!in_div) begin
            state_d = StMul;
          end else begin
            state_d = StDiv;
            // Special cases preload the final quotient/remainder and skip the iterations
            if (rs2_i == '0) begin
              a_d   = '1;
              rem_d = rs1_i;
              cnt_d = CntW'(XLEN);
            end else if (in_sdiv && (rs1_i == MostNeg) && (rs2_i == '1)) begin
              cnt_d = CntW'(XLEN);
            end else begin
              a_d     = mag1;
              b_d     = mag2;
              q_neg_d = in_neg1 ^ in_neg2;
              r_neg_d = in_neg1;
            end
          end
          if (ZeroBypass && (rs1_i == '0)) begin
            state_d = StDiv;
            cnt_d   = CntW'(XLEN);
            a_d     = (in_div && !op_i[1] && (rs2_i == '0)) ? '1 : '0;
            rem_d   = '0;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
          end
        end
      end
      StMul: begin
        if (cnt_q == CntW'(MUL_LATENCY - 1)) begin
          state_d  = StDone;
          result_d = mul_res;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDiv: begin
        if (cnt_q == CntW'(XLEN)) begin
          state_d  = StDone;
          result_d = div_res;
        end else begin
          a_d   = {a_q[XLEN-2:0], ~diff[XLEN]};
          rem_d = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Flush wins over everything, including a same-cycle accept; result is left untouched
    if (flush_i) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
    end
  end

  assign ready_o  = (state_q == StIdle);
  assign valid_o  = (state_q == StDone);
  assign busy_o   = (state_q != StIdle);
  assign result_o = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: expected results and latencies are queued
// when an op is driven and popped when valid_o appears.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [2:0]  op_i = '0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] result_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_res_q[$];
  int          exp_lat_q[$];

  localparam logic [2:0] OpMul = 3'd0, OpMulh = 3'd1, OpMulhsu = 3'd2, OpMulhu = 3'd3;
  localparam logic [2:0] OpDiv = 3'd4, OpDivu = 3'd5, OpRem = 3'd6, OpRemu = 3'd7;

`ifdef MDU_ZERO_BYPASS_EN
  localparam int ZeroDivLat = 1;
  localparam int ZeroMulLat = 1;
`else
  localparam int ZeroDivLat = 33;
  localparam int ZeroMulLat = 2;
`endif

  mdu_sequencer #(.XLEN(32), .MUL_LATENCY(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .flush_i  (flush_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one handshake; returns #1 after the accepting edge with operands scrambled
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    chk("ready_before_accept", {63'd0, ready_o}, 64'd1);
    valid_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    op_i    = 3'($urandom);
    rs1_i   = $urandom;
    rs2_i   = $urandom;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input int hold);
    int          n;
    int          el;
    logic [31:0] er;
    start_op(op, a, b);
    exp_res_q.push_back(exp);
    exp_lat_q.push_back(lat);
    n = 0;
    while (!valid_o && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    el = exp_lat_q.pop_front();
    er = exp_res_q.pop_front();
    chk("latency", 64'(n), 64'(el));
    chk("result", {32'd0, result_o}, {32'd0, er});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_result", {32'd0, result_o}, {32'd0, er});
      chk("hold_flags", {61'd0, valid_o, ready_o, busy_o}, 64'b101);
    end
    @(negedge clk);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    chk("retire_idle", {61'd0, valid_o, ready_o, busy_o}, 64'b010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic [63:0] p;
    bit          seen;

    #12;
    chk("reset_flags", {61'd0, valid_o, ready_o, busy_o}, 64'b010);
    chk("reset_result", {32'd0, result_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Signed divide and special cases
    do_op(OpDiv, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
    do_op(OpRem, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33, 0);
    do_op(OpDiv, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, 0);
    do_op(OpRem, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, 0);
    do_op(OpDivu, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1, 0);
    do_op(OpRemu, 32'h5, 32'h0, 32'h5, 1, 0);
    do_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    do_op(OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0);

    // Multiply family
    do_op(OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0);
    do_op(OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 0);
    do_op(OpMul, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2, 5);
    do_op(OpMulh, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, 0);

    // Random unsigned ops against a 64-bit model
    for (int i = 0; i < 4; i++) begin
      a = $urandom | 32'h100;
      b = $urandom_range(1, 32'hFFFF);
      do_op(OpDivu, a, b, a / b, 33, 0);
      do_op(OpRemu, a, b, a % b, 33, 0);
      b = $urandom;
      p = {32'd0, a} * {32'd0, b};
      do_op(OpMulhu, a, b, p[63:32], 2, 0);
      do_op(OpMul, a, b, p[31:0], 2, 0);
    end

    // Flush in DIV iteration 10, then a MUL must run normally
    start_op(OpDivu, 32'hDEAD_BEEF, 32'h3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    chk("flush_idle", {61'd0, valid_o, ready_o, busy_o}, 64'b010);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (valid_o) seen = 1'b1;
    end
    chk("flush_no_valid", {63'd0, seen}, 64'd0);
    do_op(OpMul, 32'd3, 32'd4, 32'd12, 2, 0);

    // Flush alongside valid in IDLE: no accept
    @(negedge clk);
    valid_i = 1'b1;
    flush_i = 1'b1;
    op_i    = OpMul;
    rs1_i   = 32'd5;
    rs2_i   = 32'd6;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    flush_i = 1'b0;
    chk("flush_accept_void", {62'd0, ready_o, busy_o}, 64'b10);
    repeat (3) @(posedge clk);
    #1;
    chk("flush_accept_noval", {63'd0, valid_o}, 64'd0);
    chk("flush_result_kept", {32'd0, result_o}, 64'd12);

    // Zero operand ops (bypass-dependent latency)
    do_op(OpDivu, 32'h0, 32'd7, 32'h0, ZeroDivLat, 0);
    do_op(OpMul, 32'h0, 32'd5, 32'h0, ZeroMulLat, 0);

    // Async reset mid-DIV, checked between clock edges
    do_op(OpDivu, 32'd100, 32'd7, 32'd14, 33, 0);
    start_op(OpDiv, 32'h0000_1234, 32'h0000_0011);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_flags", {61'd0, valid_o, ready_o, busy_o}, 64'b010);
    chk("async_rst_result", {32'd0, result_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(OpRemu, 32'd100, 32'd7, 32'd2, 33, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
